// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: phase codes, lamp codes and the legal phase order.
// The light controller imports the same package so both ends agree on the encoding.
package tl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RED       = 3'd1,
    RED2GREEN = 3'd2,
    GREEN     = 3'd3,
    GREEN2RED = 3'd4,
    FAULT     = 3'd7
  } phase_e;

  // Lamp bus is {red, yellow, green}
  localparam logic [2:0] LAMP_DARK  = 3'b000;
  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_R2G   = 3'b110;
  localparam logic [2:0] LAMP_GREEN = 3'b001;
  localparam logic [2:0] LAMP_G2R   = 3'b010;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      IDLE:      return RED;
      RED:       return RED2GREEN;
      RED2GREEN: return GREEN;
      GREEN:     return GREEN2RED;
      GREEN2RED: return RED;
      default:   return IDLE;
    endcase
  endfunction

  // Any lamp pattern the controller never drives maps to FAULT
  function automatic phase_e lamp_decode(input logic [2:0] l);
    case (l)
      LAMP_DARK:  return IDLE;
      LAMP_RED:   return RED;
      LAMP_R2G:   return RED2GREEN;
      LAMP_GREEN: return GREEN;
      LAMP_G2R:   return GREEN2RED;
      default:    return FAULT;
    endcase
  endfunction

endpackage

// File: rtl/tt_um_ja_light_monitor_if.sv
// Lamp bus from the controller plus the monitor's status outputs.
interface tt_um_ja_light_monitor_if #(parameter int CNT_W = 7);
  logic [2:0]       lamp_in;
  logic             fault_clr;
  logic [2:0]       phase_o;
  logic [CNT_W-1:0] dwell_o;
  logic             go_o;
  logic             seq_err_o;
  logic             time_err_o;
  logic             cycle_done_o;
  logic             fault_o;
  logic [7:0]       err_cnt_o;

  modport master (
    output lamp_in, fault_clr,
    input  phase_o, dwell_o, go_o, seq_err_o, time_err_o, cycle_done_o, fault_o, err_cnt_o
  );
  modport slave (
    input  lamp_in, fault_clr,
    output phase_o, dwell_o, go_o, seq_err_o, time_err_o, cycle_done_o, fault_o, err_cnt_o
  );
endinterface

// File: rtl/tl_dwell_timer.sv
// Saturating dwell counter with restart/clear, compared against an expected dwell +/- TOL.
module tl_dwell_timer #(
  parameter int CNT_W = 7,
  parameter int TOL   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             zero,
  input  logic [CNT_W-1:0] exp_dwell,
  output logic [CNT_W-1:0] cnt,
  output logic             early,
  output logic             late,
  output logic             wd
);
  localparam int W1 = CNT_W + 1;
  localparam logic [W1-1:0] TOL_W = W1'(TOL);

  logic [W1-1:0] cnt_w, exp_w, hi;

  always_ff @(posedge clk) begin
    if (rst || zero)             cnt <= '0;
    else if (restart)            cnt <= CNT_W'(1);
    else if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
  end

  // One extra bit so exp+TOL cannot wrap and exp-TOL never underflows
  assign cnt_w = {1'b0, cnt};
  assign exp_w = {1'b0, exp_dwell};
  assign hi    = exp_w + TOL_W;
  assign early = (cnt_w + TOL_W) < exp_w;
  assign late  = cnt_w > hi;
  // Next hold cycle takes the count to exp+TOL+1
  assign wd    = cnt_w == hi;
endmodule

// File: rtl/tt_um_ja_light_monitor.sv
// Traffic-light lamp monitor: samples the lamp bus, tracks phase and dwell, and flags
// order/timing errors, illegal lamp codes and completed cycles. Latency lamp_in->outputs is 2.
module tt_um_ja_light_monitor
  import tl_pkg::*;
#(
  parameter int CNT_W       = 7,
  parameter int DWELL_RED   = 32,
  parameter int DWELL_R2G   = 3,
  parameter int DWELL_GREEN = 20,
  parameter int DWELL_G2R   = 3,
  parameter int TOL         = 1
) (
  input logic                     clk,
  input logic                     rst,
  tt_um_ja_light_monitor_if.slave bus
);
  logic [2:0]       lamp_q;
  phase_e           phase, phase_n, lamp_ph;
  logic             synced, synced_n, wd_fired, wd_n, fault_q, fault_n;
  logic             seq_q, seq_n, time_q, time_n, done_q, done_n, evt;
  logic [7:0]       err_cnt;
  logic             restart, zero, early, late, wd;
  logic [CNT_W-1:0] dwell, exp_dwell;

  assign lamp_ph = lamp_decode(lamp_q);

  always_comb begin
    case (phase)
      RED:       exp_dwell = CNT_W'(DWELL_RED);
      RED2GREEN: exp_dwell = CNT_W'(DWELL_R2G);
      GREEN:     exp_dwell = CNT_W'(DWELL_GREEN);
      GREEN2RED: exp_dwell = CNT_W'(DWELL_G2R);
      default:   exp_dwell = '0;
    endcase
  end

  tl_dwell_timer #(.CNT_W(CNT_W), .TOL(TOL)) u_timer (
    .clk(clk), .rst(rst), .restart(restart), .zero(zero), .exp_dwell(exp_dwell),
    .cnt(dwell), .early(early), .late(late), .wd(wd)
  );

  always_comb begin
    phase_n  = phase;
    synced_n = synced;
    wd_n     = wd_fired;
    fault_n  = fault_q;
    seq_n    = 1'b0;
    time_n   = 1'b0;
    done_n   = 1'b0;
    evt      = 1'b0;
    restart  = 1'b0;
    zero     = 1'b0;
    if (phase == FAULT) begin
      // An illegal code in the same cycle keeps us parked in FAULT
      if (lamp_ph != FAULT && bus.fault_clr) begin
        phase_n  = IDLE;
        synced_n = 1'b0;
        fault_n  = 1'b0;
        wd_n     = 1'b0;
        zero     = 1'b1;
      end
    end else if (lamp_ph == FAULT) begin
      phase_n = FAULT;
      fault_n = 1'b1;
      wd_n    = 1'b0;
      restart = 1'b1;
      evt     = 1'b1;
    end else if (lamp_ph != phase) begin
      phase_n = lamp_ph;
      wd_n    = 1'b0;
      restart = 1'b1;
      if (lamp_ph == IDLE) synced_n = 1'b0;
      else if (phase != IDLE) begin
        // The first real phase seen after IDLE may be partial, so its exit only arms checking
        synced_n = 1'b1;
        if (synced) begin
          if (lamp_ph != next_phase(phase)) seq_n = 1'b1;
          else begin
            time_n = !wd_fired && (early || late);
            done_n = (phase == GREEN2RED) && !wd_fired && !(early || late);
          end
        end
      end
    end else if (synced && phase != IDLE && !wd_fired && wd) begin
      time_n = 1'b1;
      wd_n   = 1'b1;
    end
    evt = evt || seq_n || time_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lamp_q   <= '0;
      phase    <= IDLE;
      synced   <= 1'b0;
      wd_fired <= 1'b0;
      fault_q  <= 1'b0;
      seq_q    <= 1'b0;
      time_q   <= 1'b0;
      done_q   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      lamp_q   <= bus.lamp_in;
      phase    <= phase_n;
      synced   <= synced_n;
      wd_fired <= wd_n;
      fault_q  <= fault_n;
      seq_q    <= seq_n;
      time_q   <= time_n;
      done_q   <= done_n;
      if (evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.phase_o      = phase;
  assign bus.dwell_o      = dwell;
  assign bus.go_o         = (phase == GREEN);
  assign bus.seq_err_o    = seq_q;
  assign bus.time_err_o   = time_q;
  assign bus.cycle_done_o = done_q;
  assign bus.fault_o      = fault_q;
  assign bus.err_cnt_o    = err_cnt;
endmodule

// File: tb/tb_tt_um_ja_light_monitor.sv
// Directed bench for the lamp monitor: a table of lamp segments with hand-computed results,
// followed by hand-written reset and error-counter saturation sequences.
module tb_tt_um_ja_light_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_um_ja_light_monitor_if #(.CNT_W(7)) bus();

  tt_um_ja_light_monitor #(
    .CNT_W(7), .DWELL_RED(32), .DWELL_R2G(3), .DWELL_GREEN(20), .DWELL_G2R(3), .TOL(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int tests = 0, fails = 0;
  int seq_n = 0, time_n = 0, done_n = 0, go_n = 0, time_dw = 0;

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.seq_err_o)    seq_n++;
      if (bus.time_err_o)   time_n++;
      if (bus.cycle_done_o) done_n++;
      if (bus.go_o)         go_n++;
      if (bus.time_err_o && time_dw == 0) time_dw = int'(bus.dwell_o);
    end
  end

  typedef struct {
    logic [2:0] lamp;
    logic       clr;
    int n;
    int ph, dw, go, flt, err, seq, tim, done, goc;
  } vec_t;

  localparam int NV = 29;
  vec_t v[NV];

  task automatic tick(input logic [2:0] l, input logic c);
    bus.lamp_in   = l;
    bus.fault_clr = c;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int ph, input int dw, input int go,
                         input int flt, input int err);
    chk({nm, " phase"},   int'(bus.phase_o),   ph);
    chk({nm, " dwell"},   int'(bus.dwell_o),   dw);
    chk({nm, " go"},      int'(bus.go_o),      go);
    chk({nm, " fault"},   int'(bus.fault_o),   flt);
    chk({nm, " err_cnt"}, int'(bus.err_cnt_o), err);
  endtask

  initial begin
    //        lamp    clr  n   ph dw  go f err seq tim done goc
    v[0]  = '{3'b000, 1'b0, 3,  0, 3,  0, 0, 0, 0, 0, 0, 0};
    v[1]  = '{3'b100, 1'b0, 32, 1, 31, 0, 0, 0, 0, 0, 0, 0};
    v[2]  = '{3'b110, 1'b0, 3,  2, 2,  0, 0, 0, 0, 0, 0, 0};
    v[3]  = '{3'b001, 1'b0, 20, 3, 19, 1, 0, 0, 0, 0, 0, 19};
    v[4]  = '{3'b010, 1'b0, 3,  4, 2,  0, 0, 0, 0, 0, 0, 20};
    v[5]  = '{3'b100, 1'b0, 32, 1, 31, 0, 0, 0, 0, 0, 1, 20};
    v[6]  = '{3'b100, 1'b0, 8,  1, 39, 0, 0, 1, 0, 1, 1, 20};
    v[7]  = '{3'b110, 1'b0, 3,  2, 2,  0, 0, 1, 0, 1, 1, 20};
    v[8]  = '{3'b001, 1'b0, 20, 3, 19, 1, 0, 1, 0, 1, 1, 39};
    v[9]  = '{3'b010, 1'b0, 3,  4, 2,  0, 0, 1, 0, 1, 1, 40};
    v[10] = '{3'b100, 1'b0, 29, 1, 28, 0, 0, 1, 0, 1, 2, 40};
    v[11] = '{3'b110, 1'b0, 3,  2, 2,  0, 0, 2, 0, 2, 2, 40};
    v[12] = '{3'b001, 1'b0, 20, 3, 19, 1, 0, 2, 0, 2, 2, 59};
    v[13] = '{3'b010, 1'b0, 3,  4, 2,  0, 0, 2, 0, 2, 2, 60};
    v[14] = '{3'b100, 1'b0, 32, 1, 31, 0, 0, 2, 0, 2, 3, 60};
    v[15] = '{3'b001, 1'b0, 5,  3, 4,  1, 0, 3, 1, 2, 3, 64};
    v[16] = '{3'b111, 1'b0, 2,  7, 1,  0, 1, 4, 1, 2, 3, 65};
    v[17] = '{3'b100, 1'b0, 5,  7, 6,  0, 1, 4, 1, 2, 3, 65};
    v[18] = '{3'b100, 1'b1, 1,  0, 0,  0, 0, 4, 1, 2, 3, 65};
    v[19] = '{3'b100, 1'b0, 31, 1, 31, 0, 0, 4, 1, 2, 3, 65};
    v[20] = '{3'b110, 1'b0, 3,  2, 2,  0, 0, 4, 1, 2, 3, 65};
    v[21] = '{3'b001, 1'b0, 20, 3, 19, 1, 0, 4, 1, 2, 3, 84};
    v[22] = '{3'b010, 1'b0, 3,  4, 2,  0, 0, 4, 1, 2, 3, 85};
    v[23] = '{3'b100, 1'b0, 33, 1, 32, 0, 0, 4, 1, 2, 4, 85};
    v[24] = '{3'b110, 1'b0, 2,  2, 1,  0, 0, 4, 1, 2, 4, 85};
    v[25] = '{3'b001, 1'b0, 19, 3, 18, 1, 0, 4, 1, 2, 4, 103};
    v[26] = '{3'b010, 1'b0, 4,  4, 3,  0, 0, 4, 1, 2, 4, 104};
    v[27] = '{3'b100, 1'b0, 2,  1, 1,  0, 0, 4, 1, 2, 5, 104};
    v[28] = '{3'b110, 1'b0, 2,  2, 1,  0, 0, 5, 1, 3, 5, 104};

    // Reset dominates an illegal lamp code
    rst = 1'b1;
    tick(3'b111, 1'b0);
    tick(3'b111, 1'b0);
    chk_all("reset", 0, 0, 0, 0, 0);
    chk("reset pulses", int'({bus.seq_err_o, bus.time_err_o, bus.cycle_done_o}), 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < v[i].n; k++) tick(v[i].lamp, v[i].clr);
      chk_all($sformatf("v%0d", i), v[i].ph, v[i].dw, v[i].go, v[i].flt, v[i].err);
      chk($sformatf("v%0d seq_cnt", i),  seq_n,  v[i].seq);
      chk($sformatf("v%0d time_cnt", i), time_n, v[i].tim);
      chk($sformatf("v%0d done_cnt", i), done_n, v[i].done);
      chk($sformatf("v%0d go_cnt", i),   go_n,   v[i].goc);
    end
    chk("watchdog dwell", time_dw, 34);

    // Reset mid-GREEN
    for (int k = 0; k < 5; k++) tick(3'b001, 1'b0);
    chk("pre-rst go", int'(bus.go_o), 1);
    chk("pre-rst dwell", int'(bus.dwell_o), 4);
    rst = 1'b1;
    tick(3'b001, 1'b0);
    chk_all("mid rst", 0, 0, 0, 0, 0);
    chk("mid rst pulses", int'({bus.seq_err_o, bus.time_err_o, bus.cycle_done_o}), 0);
    rst = 1'b0;

    // Sync up, then alternate GREEN/RED every cycle: each change is an illegal successor
    tick(3'b000, 1'b0);
    tick(3'b000, 1'b0);
    for (int k = 0; k < 3; k++) tick(3'b100, 1'b0);
    for (int k = 0; k < 3; k++) tick(3'b110, 1'b0);
    for (int k = 0; k < 310; k++) tick((k % 2 == 0) ? 3'b001 : 3'b100, 1'b0);
    for (int k = 0; k < 3; k++) tick(3'b100, 1'b0);
    chk_all("saturate", 1, 3, 0, 0, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
